// File: rtl/key_pkg.sv
// Shared constants for the key event path: default key count and debounced level encoding.
package key_pkg;
  localparam int   DEF_N_KEYS   = 4;
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;
endpackage

// File: rtl/key_rr_arb.sv
// Combinational round-robin pick over the pending vector, starting just after last_id.
// Zero latency; no backpressure of its own, the caller decides when a grant is used.
module key_rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   pend,
  input  logic [IDW-1:0] last_id,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);
  int idx;

  // Scan from farthest to nearest so the key closest after last_id wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_id) + k) % N;
      if (pend[idx[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/key_evt_sched.sv
// Queues one press/auto-repeat event per key and issues them round-robin on a valid/ready port.
// Flag to cmd_valid in 2 cycles; output holds under !cmd_ready, colliding events pulse evt_drop.
module key_evt_sched
  import key_pkg::*;
#(
  parameter int N_KEYS     = DEF_N_KEYS,
  parameter int IDW        = $clog2(N_KEYS),
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter bit RPT_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_flag,
  input  logic [N_KEYS-1:0] key_state,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [IDW-1:0]    cmd_id,
  output logic              cmd_repeat,
  output logic              evt_drop
);
  localparam int MAXC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW   = $clog2(MAXC);

  logic [N_KEYS-1:0] press_ev, rel_ev, rpt_ev;
  logic [N_KEYS-1:0] pending_q, pending_d, pend_rpt_q, pend_rpt_d;
  logic [IDW-1:0]    last_id_q, last_id_d, cmd_id_q, cmd_id_d;
  logic              cmd_valid_q, cmd_valid_d, cmd_repeat_q, cmd_repeat_d;
  logic              evt_drop_q, evt_drop_d;
  logic              load, grant_valid;
  logic [IDW-1:0]    grant_id;

  always_comb begin
    press_ev = '0;
    rel_ev   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      press_ev[i] = key_flag[i] && (key_state[i] == KEY_PRESSED);
      rel_ev[i]   = key_flag[i] && (key_state[i] == KEY_RELEASED);
    end
  end

  generate
    if (RPT_EN) begin : g_rpt
      localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
      localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYC - 1);
      logic [N_KEYS-1:0]         pressed_q, pressed_d, phase_q, phase_d;
      logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;

      // phase selects the initial hold interval (0) or the repeat interval (1).
      always_comb begin
        pressed_d = pressed_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rpt_ev    = '0;
        for (int i = 0; i < N_KEYS; i++) begin
          rpt_ev[i] = pressed_q[i] && (cnt_q[i] == (phase_q[i] ? RPT_LAST : HOLD_LAST));
          if (press_ev[i] || rel_ev[i]) begin
            pressed_d[i] = press_ev[i];
            phase_d[i]   = 1'b0;
            cnt_d[i]     = '0;
          end else if (rpt_ev[i]) begin
            phase_d[i] = 1'b1;
            cnt_d[i]   = '0;
          end else if (pressed_q[i]) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pressed_q <= '0;
          phase_q   <= '0;
          cnt_q     <= '0;
        end else begin
          pressed_q <= pressed_d;
          phase_q   <= phase_d;
          cnt_q     <= cnt_d;
        end
      end
    end else begin : g_no_rpt
      assign rpt_ev = '0;
    end
  endgenerate

  key_rr_arb #(.N(N_KEYS), .IDW(IDW)) u_arb (
    .pend        (pending_q),
    .last_id     (last_id_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign load = !cmd_valid_q || cmd_ready;

  always_comb begin
    pending_d    = pending_q;
    pend_rpt_d   = pend_rpt_q;
    last_id_d    = last_id_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_id_d     = cmd_id_q;
    cmd_repeat_d = cmd_repeat_q;
    evt_drop_d   = 1'b0;
    if (load) begin
      cmd_valid_d = grant_valid;
      if (grant_valid) begin
        cmd_id_d     = grant_id;
        cmd_repeat_d = pend_rpt_q[grant_id];
        last_id_d    = grant_id;
      end
    end
    // A slot being drained this cycle can immediately take the new event.
    for (int i = 0; i < N_KEYS; i++) begin
      if (load && grant_valid && (grant_id == IDW'(i))) begin
        pending_d[i]  = press_ev[i] || rpt_ev[i];
        pend_rpt_d[i] = !press_ev[i] && rpt_ev[i];
      end else if (press_ev[i] || rpt_ev[i]) begin
        if (pending_q[i]) begin
          evt_drop_d = 1'b1;
        end else begin
          pending_d[i]  = 1'b1;
          pend_rpt_d[i] = !press_ev[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      pend_rpt_q   <= '0;
      last_id_q    <= IDW'(N_KEYS - 1);
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      cmd_repeat_q <= 1'b0;
      evt_drop_q   <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      pend_rpt_q   <= pend_rpt_d;
      last_id_q    <= last_id_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      cmd_repeat_q <= cmd_repeat_d;
      evt_drop_q   <= evt_drop_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_id     = cmd_id_q;
  assign cmd_repeat = cmd_repeat_q;
  assign evt_drop   = evt_drop_q;
endmodule

// File: tb/tb_key_evt_sched.sv
// Scoreboard bench for key_evt_sched: stimulus queues expected commands/drops, a monitor checks them.
module tb_key_evt_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_flag = '0;
  logic [3:0] key_state = '1;
  logic       cmd_valid, cmd_ready = 1'b0;
  logic [1:0] cmd_id;
  logic       cmd_repeat, evt_drop;

  typedef struct {
    int id;
    int rpt;
    int cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         drop_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] lvl = '1;
  logic       prev_hold = 1'b0;
  int         prev_id = 0;
  int         prev_rpt = 0;

  key_evt_sched #(
    .N_KEYS(4), .HOLD_CYC(8), .REPEAT_CYC(4), .RPT_EN(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_flag   (key_flag),
    .key_state  (key_state),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_repeat (cmd_repeat),
    .evt_drop   (evt_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: consumes expected commands on handshakes and expected drop pulses.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cmd: got id=%0d rpt=%0d at cyc %0d, required no command", cmd_id, cmd_repeat, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cmd_id !== 2'(e.id) || cmd_repeat !== 1'(e.rpt) || (e.cyc >= 0 && cyc != e.cyc)) begin
            bad++;
            $display("FAIL cmd: got id=%0d rpt=%0d cyc=%0d, required id=%0d rpt=%0d cyc=%0d",
                     cmd_id, cmd_repeat, cyc, e.id, e.rpt, e.cyc);
          end
        end
      end
      if (prev_hold && cmd_valid) begin
        total++;
        if (cmd_id !== 2'(prev_id) || cmd_repeat !== 1'(prev_rpt)) begin
          bad++;
          $display("FAIL hold_stable: got id=%0d rpt=%0d, required id=%0d rpt=%0d", cmd_id, cmd_repeat, prev_id, prev_rpt);
        end
      end
      if (evt_drop) begin
        total++;
        if (drop_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_drop: got drop at cyc %0d, required none", cyc);
        end else begin
          d = drop_q.pop_front();
          if (cyc != d) begin
            bad++;
            $display("FAIL drop_cyc: got %0d, required %0d", cyc, d);
          end
        end
      end
    end
    prev_hold = rst_n && cmd_valid && !cmd_ready;
    prev_id   = int'(cmd_id);
    prev_rpt  = int'(cmd_repeat);
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_cmd(input int id, input int rpt, input int cy);
    exp_t e;
    e.id = id; e.rpt = rpt; e.cyc = cy;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] m);
    lvl       = lvl & ~m;
    key_state = lvl;
    key_flag  = m;
    tick(1);
    key_flag  = '0;
  endtask

  task automatic release_k(input logic [3:0] m);
    lvl       = lvl | m;
    key_state = lvl;
    key_flag  = m;
    tick(1);
    key_flag  = '0;
  endtask

  initial begin
    int c;
    tick(3);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_id", int'(cmd_id), 0);
    chk("rst_repeat", int'(cmd_repeat), 0);
    chk("rst_drop", int'(evt_drop), 0);
    rst_n = 1'b1;
    tick(2);

    // Single press of key 2.
    cmd_ready = 1'b1;
    c = cyc;
    exp_cmd(2, 0, c + 2);
    press(4'b0100); tick(1); release_k(4'b0100); tick(8);

    // Keys 0 and 1 together: back-to-back commands, key 0 first after last_id=2.
    c = cyc;
    exp_cmd(0, 0, c + 2);
    exp_cmd(1, 0, c + 3);
    press(4'b0011); tick(1); release_k(4'b0011); tick(8);

    // Stalled consumer: second press queues behind the output, third is dropped.
    cmd_ready = 1'b0;
    c = cyc;
    press(4'b1000); tick(1); release_k(4'b1000); tick(2);
    press(4'b1000); tick(1); release_k(4'b1000); tick(2);
    drop_q.push_back(c + 11);
    press(4'b1000); tick(1); release_k(4'b1000); tick(1);
    chk("stall_valid", int'(cmd_valid), 1);
    chk("stall_id", int'(cmd_id), 3);
    exp_cmd(3, 0, c + 14);
    exp_cmd(3, 0, c + 15);
    cmd_ready = 1'b1;
    tick(8);

    // Round robin: set last_id=1, then keys 0 and 2 together -> 2 before 0.
    c = cyc;
    exp_cmd(1, 0, c + 2);
    press(4'b0010); tick(1); release_k(4'b0010); tick(6);
    c = cyc;
    exp_cmd(2, 0, c + 2);
    exp_cmd(0, 0, c + 3);
    press(4'b0101); tick(1); release_k(4'b0101); tick(8);

    // Auto-repeat: key 1 held 20 cycles, repeat events at 8, 12, 16, 20.
    c = cyc;
    exp_cmd(1, 0, c + 2);
    exp_cmd(1, 1, c + 10);
    exp_cmd(1, 1, c + 14);
    exp_cmd(1, 1, c + 18);
    exp_cmd(1, 1, c + 22);
    press(4'b0010); tick(19); release_k(4'b0010); tick(30);

    // Reset with a held command and three keys pending.
    cmd_ready = 1'b0;
    press(4'b0001); tick(1);
    press(4'b1110); tick(3);
    chk("pre_rst_valid", int'(cmd_valid), 1);
    chk("pre_rst_id", int'(cmd_id), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(cmd_valid), 0);
    chk("mid_rst_id", int'(cmd_id), 0);
    chk("mid_rst_repeat", int'(cmd_repeat), 0);
    chk("mid_rst_drop", int'(evt_drop), 0);
    tick(2);
    lvl = '1;
    key_state = lvl;
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    tick(20);

    chk("exp_left", exp_q.size(), 0);
    chk("drop_left", drop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
